uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter between up to eight byte sources. It accepts one byte at a time from requesters on a req/ack handshake and presents it to the transmitter's `din_rdy`/`din_byte` inputs. It then tracks the transmitter's `uart_ready` through the frame, so exactly one byte is in flight at any time. It also supports per-requester locking, so a multi-byte message is sent without interleaving.

---
 rtl/uart_tx_arbiter_if.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Purpose  : Bundle of requester handshake, transmitter kick and arbiter
//             status signals shared between the byte sources, the arbiter
//             and the UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic              tx_din_rdy;
    logic [7:0]        tx_din_byte;
    logic              tx_uart_ready;
    logic [2:0]        owner;
    logic              owner_vld;
    logic              busy;
    logic              err_timeout;

    // Requesters plus transmitter side: drives requests and transmitter status
    modport master (
        output req,
        output lock,
        output data,
        output tx_uart_ready,
        input  ack,
        input  tx_din_rdy,
        input  tx_din_byte,
        input  owner,
        input  owner_vld,
        input  busy,
        input  err_timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  lock,
        input  data,
        input  tx_uart_ready,
        output ack,
        output tx_din_rdy,
        output tx_din_byte,
        output owner,
        output owner_vld,
        output busy,
        output err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one UART transmitter
//             between up to eight byte sources, with per-owner locking and a
//             start-of-frame timeout. Exactly one byte is in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE       = 2'd0;
    localparam logic [1:0] c_ST_KICK       = 2'd1;
    localparam logic [1:0] c_ST_WAIT_START = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE  = 2'd3;

    // Owner resets to the last index so requester 0 is searched first
    localparam logic [2:0] c_OWNER_RST = 3'(NREQ - 1);
    localparam logic [7:0] c_START_TO  = 8'(START_TO);

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_ack;
    logic            r_din_rdy;
    logic [7:0]      r_din_byte;
    logic [2:0]      r_owner;
    logic            r_owner_vld;
    logic            r_err;
    logic [7:0]      r_cnt;

    logic [7:0]      w_req8;
    logic [7:0]      w_lock8;
    logic            w_win_vld;
    logic [2:0]      w_win_idx;
    logic [3:0]      w_cand;
    logic [7:0]      w_win_byte;
    logic [NREQ-1:0] w_win_onehot;
    logic [7:0]      w_cnt_inc;

    // Pad request/lock vectors to eight so a 3-bit owner can index them
    assign w_req8  = 8'(bus.req);
    assign w_lock8 = 8'(bus.lock);

    // Saturating increment: the counter must never wrap back to zero
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);

    // Winner selection: locked owner only, otherwise nearest request after owner
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = r_owner;
        w_cand    = '0;
        if (r_owner_vld) begin
            w_win_vld = w_req8[r_owner];
            w_win_idx = r_owner;
        end else begin
            // Walk from farthest to nearest so the closest candidate wins last
            for (int k = NREQ; k >= 1; k--) begin
                w_cand = 4'(r_owner) + 4'(k);
                if (w_cand >= 4'(NREQ)) begin
                    w_cand = w_cand - 4'(NREQ);
                end
                if (w_req8[w_cand[2:0]]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = w_cand[2:0];
                end
            end
        end
    end

    // Data mux and one-hot acknowledge for the selected requester
    always_comb begin
        w_win_byte   = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win_idx == 3'(i)) begin
                w_win_byte      = bus.data[8*i +: 8];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // Grant / kick / frame-tracking state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_ack       <= '0;
            r_din_rdy   <= 1'b0;
            r_din_byte  <= 8'h00;
            r_owner     <= c_OWNER_RST;
            r_owner_vld <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 8'h00;
        end else begin
            r_ack     <= '0;
            r_din_rdy <= 1'b0;
            r_err     <= 1'b0;

            // Owner dropped its lock: release on this edge, grant may override
            if (r_owner_vld && !w_lock8[r_owner]) begin
                r_owner_vld <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.tx_uart_ready && w_win_vld) begin
                        r_din_byte  <= w_win_byte;
                        r_din_rdy   <= 1'b1;
                        r_ack       <= w_win_onehot;
                        r_owner     <= w_win_idx;
                        r_owner_vld <= w_lock8[w_win_idx];
                        r_state     <= c_ST_KICK;
                    end
                end
                c_ST_KICK: begin
                    r_cnt   <= 8'h00;
                    r_state <= c_ST_WAIT_START;
                end
                c_ST_WAIT_START: begin
                    // A falling ready wins over a coincident timeout
                    if (!bus.tx_uart_ready) begin
                        r_state <= c_ST_WAIT_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == c_START_TO) begin
                            r_err       <= 1'b1;
                            r_owner_vld <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (bus.tx_uart_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.tx_din_rdy  = r_din_rdy;
    assign bus.tx_din_byte = r_din_byte;
    assign bus.owner       = r_owner;
    assign bus.owner_vld   = r_owner_vld;
    assign bus.err_timeout = r_err;
    assign bus.busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Self-checking bench for uart_tx_arbiter: a timestamp-based
//             reference model checked every cycle, plus directed scenarios
//             with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int START_TO = 15;
    localparam int FRAME    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ     (NREQ),
        .START_TO (START_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- shared stimulus state ----------------
    int              rem [NREQ] = '{default: 0};
    logic [7:0]      nbyte [NREQ];
    logic [NREQ-1:0] ack_d = '0;
    bit              tx_mute  = 1'b0;
    bit              tx_block = 1'b0;
    int              tx_t     = 0;
    int              act_log [$];

    int exp_rr   [5] = '{0, 1, 2, 3, 0};
    int exp_lock [5] = '{1, 1, 1, 3, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int k);
        return (k < act_log.size()) ? act_log[k] : -1;
    endfunction

    function automatic bit all_done();
        bit d;
        d = (bus.busy === 1'b0) && (ack_d == '0);
        for (int i = 0; i < NREQ; i++) if (rem[i] != 0) d = 1'b0;
        return d;
    endfunction

    // Requesters and transmitter model, driven 1 time unit after each edge
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            // Byte taken last cycle: drop it and present the next one
            if (ack_d[i]) begin
                if (rem[i] > 0) rem[i] = rem[i] - 1;
                nbyte[i] = nbyte[i] + 8'h11;
            end
            ack_d[i] = bus.ack[i];
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]          = (rem[i] > 0);
            bus.data[8*i +: 8]  = nbyte[i];
        end
        if (bus.tx_din_rdy === 1'b1 && !tx_mute) tx_t = FRAME + 1;
        else if (tx_t > 0) tx_t = tx_t - 1;
        bus.tx_uart_ready = !tx_block && (tx_t == 0 || tx_t > FRAME);
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic              p_rst   = 1'b1;
    logic [NREQ-1:0]   p_req   = '0;
    logic [NREQ-1:0]   p_lock  = '0;
    logic [8*NREQ-1:0] p_data  = '0;
    logic              p_ready = 1'b0;
    int                mcyc    = 0;
    int                m_grant = 0;
    bit                m_idle  = 1'b1;
    bit                m_fell  = 1'b0;
    bit                m_locked = 1'b0;
    int                m_owner = NREQ - 1;
    logic [7:0]        m_byte  = 8'h00;

    always @(negedge clk) begin
        bit              grant;
        bit              tmo;
        int              w;
        int              age;
        int              c;
        logic [NREQ-1:0] e_ack;
        grant = 1'b0;
        tmo   = 1'b0;
        w     = 0;
        e_ack = '0;
        if (p_rst) begin
            m_idle   = 1'b1;
            m_owner  = NREQ - 1;
            m_locked = 1'b0;
            m_byte   = 8'h00;
        end else begin
            if (m_idle) begin
                if (p_ready) begin
                    if (m_locked) begin
                        if (p_req[m_owner]) begin grant = 1'b1; w = m_owner; end
                    end else begin
                        for (int k = 1; k <= NREQ; k++) begin
                            c = (m_owner + k) % NREQ;
                            if (!grant && p_req[c]) begin grant = 1'b1; w = c; end
                        end
                    end
                end
            end else begin
                age = mcyc - m_grant;
                if (age >= 2) begin
                    if (!m_fell) begin
                        if (!p_ready) m_fell = 1'b1;
                        else if (age == START_TO + 1) tmo = 1'b1;
                    end else if (p_ready) begin
                        m_idle = 1'b1;
                    end
                end
            end
            if (m_locked && !p_lock[m_owner]) m_locked = 1'b0;
            if (tmo) begin m_idle = 1'b1; m_locked = 1'b0; end
            if (grant) begin
                m_idle   = 1'b0;
                m_fell   = 1'b0;
                m_grant  = mcyc;
                m_owner  = w;
                m_locked = p_lock[w];
                m_byte   = p_data[8*w +: 8];
                e_ack[w] = 1'b1;
            end
        end

        chk("ack",         32'(bus.ack),         32'(e_ack));
        chk("tx_din_rdy",  32'(bus.tx_din_rdy),  32'(grant));
        chk("tx_din_byte", 32'(bus.tx_din_byte), 32'(m_byte));
        chk("owner",       32'(bus.owner),       32'(m_owner));
        chk("owner_vld",   32'(bus.owner_vld),   32'(m_locked));
        chk("busy",        32'(bus.busy),        32'(!m_idle));
        chk("err_timeout", 32'(bus.err_timeout), 32'(tmo));

        if (bus.tx_din_rdy === 1'b1) begin
            for (int i = 0; i < NREQ; i++) if (bus.ack[i] === 1'b1) act_log.push_back(i);
        end

        p_rst   = rst;
        p_req   = bus.req;
        p_lock  = bus.lock;
        p_data  = bus.data;
        p_ready = bus.tx_uart_ready;
        mcyc++;
    end

    // ---------------- directed scenarios ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 300 && !all_done(); i++) step();
        chk(nm, 32'(all_done()), 32'd1);
    endtask

    initial begin
        int  n;
        int  n1;
        bit  seen;
        bus.lock = '0;
        for (int i = 0; i < NREQ; i++) nbyte[i] = 8'(8'h10 * (i + 1));
        rst = 1'b1;
        repeat (3) step();
        chk("rst_owner",     32'(bus.owner),       32'd3);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_ack",       32'(bus.ack),         32'd0);
        chk("rst_din_byte",  32'(bus.tx_din_byte), 32'h00);
        rst = 1'b0;
        step();

        // Round robin with all four requesting
        act_log.delete();
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        for (int i = 0; i < 400 && act_log.size() < 5; i++) step();
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(log_at(k)), 32'(exp_rr[k]));
        wait_idle("rr_idle");

        // Locked owner sends three bytes before others
        act_log.delete();
        bus.lock[1] = 1'b1;
        rem[1] = 3; rem[0] = 1; rem[3] = 1;
        n1 = 0;
        for (int i = 0; i < 600 && act_log.size() < 5; i++) begin
            step();
            if (bus.ack[1] === 1'b1) begin
                n1++;
                if (n1 == 1) chk("lock_vld", 32'(bus.owner_vld), 32'd1);
                if (n1 == 3) bus.lock[1] = 1'b0;
            end
        end
        for (int k = 0; k < 5; k++) chk("lock_order", 32'(log_at(k)), 32'(exp_lock[k]));
        wait_idle("lock_idle");

        // Single request
        nbyte[2] = 8'hA5;
        rem[2]   = 1;
        for (int i = 0; i < 50 && bus.ack == '0; i++) step();
        chk("single_ack",   32'(bus.ack),         32'h4);
        chk("single_rdy",   32'(bus.tx_din_rdy),  32'd1);
        chk("single_byte",  32'(bus.tx_din_byte), 32'hA5);
        chk("single_owner", 32'(bus.owner),       32'd2);
        step();
        chk("single_ack_off", 32'(bus.ack),        32'd0);
        chk("single_rdy_off", 32'(bus.tx_din_rdy), 32'd0);
        chk("single_busy",    32'(bus.busy),       32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50 && bus.busy === 1'b1; i++) begin
            step();
            if (bus.tx_uart_ready === 1'b0) seen = 1'b1;
        end
        chk("single_frame_seen", 32'(seen),     32'd1);
        chk("single_busy_end",   32'(bus.busy), 32'd0);
        wait_idle("single_idle");

        // Timeout: transmitter never drops ready
        tx_mute = 1'b1;
        rem[3] = 1; rem[0] = 1;
        for (int i = 0; i < 50 && bus.tx_din_rdy !== 1'b1; i++) step();
        chk("to_first_ack", 32'(bus.ack), 32'h8);
        n = 0;
        for (int i = 0; i < 60 && bus.err_timeout !== 1'b1; i++) begin
            step();
            n++;
        end
        chk("to_delay", 32'(n), 32'd16);
        chk("to_busy",  32'(bus.busy), 32'd0);
        tx_mute = 1'b0;
        step();
        chk("to_next_ack", 32'(bus.ack), 32'h1);
        wait_idle("to_idle");

        // Reset while a frame is in flight
        rem[1] = 1;
        for (int i = 0; i < 50 && !(bus.busy === 1'b1 && bus.tx_uart_ready === 1'b0); i++) step();
        step();
        act_log.delete();
        rem[0] = 1; rem[2] = 1;
        rst = 1'b1;
        step();
        chk("mrst_ack",      32'(bus.ack),         32'd0);
        chk("mrst_rdy",      32'(bus.tx_din_rdy),  32'd0);
        chk("mrst_byte",     32'(bus.tx_din_byte), 32'h00);
        chk("mrst_owner",    32'(bus.owner),       32'd3);
        chk("mrst_vld",      32'(bus.owner_vld),   32'd0);
        chk("mrst_busy",     32'(bus.busy),        32'd0);
        chk("mrst_err",      32'(bus.err_timeout), 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && act_log.size() < 2; i++) begin
            step();
            if (bus.tx_din_rdy === 1'b1 && act_log.size() == 1)
                chk("mrst_ready_before_kick", 32'(seen), 32'd1);
            if (bus.tx_uart_ready === 1'b1) seen = 1'b1;
        end
        chk("mrst_first", 32'(log_at(0)), 32'd0);
        chk("mrst_second", 32'(log_at(1)), 32'd2);
        wait_idle("mrst_idle");

        // Transmitter blocks grants
        tx_block = 1'b1;
        rem[0]   = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("blk_no_ack", 32'(bus.ack), 32'd0);
        end
        tx_block = 1'b0;
        for (int i = 0; i < 10 && bus.tx_uart_ready !== 1'b1; i++) step();
        step();
        chk("blk_ack", 32'(bus.ack),        32'h1);
        chk("blk_rdy", 32'(bus.tx_din_rdy), 32'd1);
        wait_idle("blk_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
